pdec_llr_unit_pipe: RTL
=======================

Name: pdec_llr_unit_pipe

Overview:
- Pipelined, parametrised F/G LLR engine for the polar SC/SCL decoder.
- Consumes one stage+1 LLR vector plus partial sums per beat from pdec_rd_ctrl and produces a stage LLR vector for pdec_updt_pm.
- Generalises the lane count, adds a 2-stage registered datapath with valid/ready backpressure and stage-dependent lane masking.
- Keeps running saturation statistics for fixed-point tuning.

Parameters:
- WID_INN, 10, LLR width in bits (two's complement), >=4.
- NUM_PE, 4, output lanes per beat; power of two, 1..64.
- STG_W, 4, width of the stage index.
- CNT_W, 16, width of the saturation counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld&in_rdy
- cur_fg  in  1  1=F function, 0=G function (sampled with beat)
- stage  in  STG_W  current decode stage (sampled with beat)
- llr_in_data  in  WID_INN*2*NUM_PE  {llr[2P-1]..llr0}; lane i pairs llr[i] with llr[i+NUM_PE]
- us_in_data  in  NUM_PE  partial sums, bit i for lane i (G only)
- out_vld  out  1  output beat valid
- out_rdy  in  1  downstream ready
- llr_out_data  out  WID_INN*NUM_PE  {llr[P-1]..llr0}
- sat_clr  in  1  synchronous clear of sat_cnt
- sat_cnt  out  CNT_W  count of G-lane saturations since clear

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values: in_rdy=1 (combinational from empty pipe), out_vld=0, llr_out_data=0, sat_cnt=0, all internal valids 0.
- Pipeline: S1 registers per-lane operands (abs values, signs, us-muxed a, b, fg, lane mask). S2 registers the final result. Latency is exactly 2 cycles from the accepting edge to out_vld when out_rdy=1. Throughput is 1 beat/cycle.
- Handshake:
  - s2_adv = ~out_vld | out_rdy.
  - s1_adv = ~s1_vld | s2_adv.
  - in_rdy = s1_adv.
  - Data holds stable while out_vld&~out_rdy.
  - No bubbles inserted; no beat lost or duplicated.
- Lane mask: act = min(NUM_PE, 2^stage). Lanes i>=act output 0 and never count saturation. Only stage values with 2^stage<NUM_PE mask anything.
- F (cur_fg=1), per lane: a=llr[i], b=llr[i+P].
  - |x| saturates: -2^(W-1) maps to 2^(W-1)-1.
  - m=min(|a|,|b|); on equality use |b|.
  - out = (sign a != sign b) ? -m : m.
- G (cur_fg=0), per lane: s = (us[i] ? -a : a) + b, computed in W+1 bits. -(-2^(W-1)) is evaluated in W+1 bits (= +2^(W-1)).
  - Result saturates to [-(2^(W-1)-1), 2^(W-1)-1]; symmetric range, most-negative never produced.
  - Each lane that clips increments sat_cnt by 1 when the beat leaves S2 (out_vld&out_rdy).
- sat_cnt:
  - Multiple clipped lanes in one beat add popcount.
  - Sticks at 2^CNT_W-1 (no wrap).
  - sat_clr has priority over a same-cycle increment (result 0).
- Simultaneous in accept and out drain: both occur, counts stay consistent.
- Reset mid-operation: all in-flight beats discarded; out_vld drops asynchronously.

Optional Feature:
- Macro PDEC_LLR_OFFSET_MINSUM_EN.
- When defined: F output uses offset min-sum, m' = max(m - 1, 0), sign rule unchanged. The offset is applied in S2; latency is unchanged.
- When undefined: plain min-sum as above; no offset logic synthesised.
- G path and sat_cnt are unaffected in both builds.

Test Plan:
- Reset/latency: F beat at stage=3, a={5,-7,100,0}, b={-3,-9,200,50} (W=10, P=4) -> 2 cycles later out={-3,7,100,0}; with OFFSET_EN {-2,6,99,0}.
- G saturation: a=511, b=511, us=0 on lane0; a=-512, us=1, b=10 on lane1 -> lanes 511 and 511; sat_cnt=2 after drain. Then sat_clr in the same cycle as a saturating drain -> sat_cnt=0.
- Masking: stage=1, all lanes a=1, b=2, G, us=0 -> out={0,0,3,3}. Stage=0 -> {0,0,0,3}.
- Backpressure: 6 back-to-back beats, out_rdy held low 4 cycles after the first out_vld -> in_rdy falls after 2 buffered beats, outputs emerge in order and unchanged, none lost.
- Reset mid-flight: assert rst_n=0 with 2 beats in pipe -> out_vld=0 immediately, sat_cnt=0, no stale beat after release.
- Min-sum ties: a=-512, b=-512, F -> out=511 (abs saturation, equal signs).

Source files
------------

// File: rtl/pdec_llr_unit_pipe.sv
// pdec_llr_unit_pipe: pipelined F/G LLR engine for the polar SC/SCL decoder.
// Two registered stages (S1 operands, S2 result) with valid/ready backpressure,
// stage-dependent lane masking and a sticky saturation counter for G lanes.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_vld/in_rdy              input beat handshake
//   cur_fg, stage              F(1)/G(0) select and decode stage, sampled with the beat
//   llr_in_data                2*NUM_PE LLRs; lane i pairs llr[i] with llr[i+NUM_PE]
//   us_in_data                 partial sums, bit i for lane i (G only)
//   out_vld/out_rdy            output beat handshake
//   llr_out_data               NUM_PE result LLRs
//   sat_clr, sat_cnt           clear and value of the G-lane saturation counter
// Optional build macro PDEC_LLR_OFFSET_MINSUM_EN: F uses offset min-sum max(m-1,0).
module pdec_llr_unit_pipe #(
    parameter int WID_INN = 10,
    parameter int NUM_PE  = 4,
    parameter int STG_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_vld,
    output logic                           in_rdy,
    input  logic                           cur_fg,
    input  logic [STG_W-1:0]               stage,
    input  logic [WID_INN*2*NUM_PE-1:0]    llr_in_data,
    input  logic [NUM_PE-1:0]              us_in_data,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [WID_INN*NUM_PE-1:0]      llr_out_data,
    input  logic                           sat_clr,
    output logic [CNT_W-1:0]               sat_cnt
);
    localparam int W   = WID_INN;
    localparam int P   = NUM_PE;
    localparam int PCW = $clog2(NUM_PE + 1);
    localparam logic signed [W-1:0] MAXW = W'((1 << (W - 1)) - 1);
    localparam logic signed [W-1:0] MINW = {1'b1, {(W - 1){1'b0}}};
    localparam logic signed [W:0]   MAXP = {2'b00, {(W - 1){1'b1}}};
    localparam logic signed [W:0]   MINN = {2'b11, {(W - 2){1'b0}}, 1'b1};

    logic                  w_s2_adv, w_s1_adv;
    logic                  r_s1_vld, r_s1_fg, r_s2_vld;
    logic [P-1:0]          w_neg, w_msk, w_sat, r_s1_neg, r_s1_msk;
    logic signed [W:0]     w_x [P];
    logic signed [W:0]     w_y [P];
    logic signed [W:0]     r_s1_x [P];
    logic signed [W:0]     r_s1_y [P];
    logic [W*P-1:0]        w_res, r_s2_data;
    logic [PCW-1:0]        w_pc, r_s2_pc;
    logic [CNT_W:0]        w_sum;
    logic [CNT_W-1:0]      r_sat;

    assign w_s2_adv     = ~r_s2_vld | out_rdy;
    assign w_s1_adv     = ~r_s1_vld | w_s2_adv;
    assign in_rdy       = w_s1_adv;
    assign out_vld      = r_s2_vld;
    assign llr_out_data = r_s2_data;
    assign sat_cnt      = r_sat;

    // S1 operands: F stores saturated magnitudes, G stores the us-muxed a and b in W+1 bits
    for (genvar i = 0; i < P; i++) begin : g_s1
        // lane i is active when i < 2^stage, i.e. stage >= clog2(i+1)
        localparam logic [STG_W:0] LG = (STG_W + 1)'($clog2(i + 1));
        logic signed [W-1:0] w_a, w_b, w_fa, w_fb;
        logic signed [W:0]   w_ae;
        assign w_a      = llr_in_data[i*W +: W];
        assign w_b      = llr_in_data[(i+P)*W +: W];
        assign w_fa     = (w_a == MINW) ? MAXW : (w_a[W-1] ? -w_a : w_a);
        assign w_fb     = (w_b == MINW) ? MAXW : (w_b[W-1] ? -w_b : w_b);
        assign w_ae     = {w_a[W-1], w_a};
        assign w_x[i]   = cur_fg ? {1'b0, w_fa} : (us_in_data[i] ? -w_ae : w_ae);
        assign w_y[i]   = cur_fg ? {1'b0, w_fb} : {w_b[W-1], w_b};
        assign w_neg[i] = w_a[W-1] ^ w_b[W-1];
        assign w_msk[i] = {1'b0, stage} >= LG;
    end

    // S2 result: min-sum for F, clipped sum for G, zero on masked lanes
    for (genvar i = 0; i < P; i++) begin : g_s2
        logic [W-1:0]      w_m, w_mo, w_f, w_g, w_r;
        logic signed [W:0] w_s;
        logic              w_hi, w_lo;
        // on equal magnitudes |b| is chosen; both are the same value
        assign w_m  = (r_s1_x[i] < r_s1_y[i]) ? r_s1_x[i][W-1:0] : r_s1_y[i][W-1:0];
`ifdef PDEC_LLR_OFFSET_MINSUM_EN
        assign w_mo = w_m - W'(w_m != '0);
`else
        assign w_mo = w_m;
`endif
        assign w_f  = r_s1_neg[i] ? -w_mo : w_mo;
        // -a in [-(2^(W-1)-1), 2^(W-1)] plus b cannot overflow W+1 bits
        assign w_s  = r_s1_x[i] + r_s1_y[i];
        assign w_hi = w_s > MAXP;
        assign w_lo = w_s < MINN;
        assign w_g  = w_hi ? MAXW : (w_lo ? -MAXW : w_s[W-1:0]);
        assign w_r  = !r_s1_msk[i] ? '0 : (r_s1_fg ? w_f : w_g);
        assign w_res[i*W +: W] = w_r;
        assign w_sat[i] = r_s1_msk[i] & ~r_s1_fg & (w_hi | w_lo);
    end

    always_comb begin
        w_pc = '0;
        for (int k = 0; k < P; k++) w_pc = w_pc + PCW'(w_sat[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_fg  <= 1'b0;
            r_s1_neg <= '0;
            r_s1_msk <= '0;
            for (int k = 0; k < P; k++) begin
                r_s1_x[k] <= '0;
                r_s1_y[k] <= '0;
            end
        end else if (w_s1_adv) begin
            r_s1_vld <= in_vld;
            if (in_vld) begin
                r_s1_fg  <= cur_fg;
                r_s1_neg <= w_neg;
                r_s1_msk <= w_msk;
                for (int k = 0; k < P; k++) begin
                    r_s1_x[k] <= w_x[k];
                    r_s1_y[k] <= w_y[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld  <= 1'b0;
            r_s2_data <= '0;
            r_s2_pc   <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_data <= w_res;
                r_s2_pc   <= w_pc;
            end
        end
    end

    // saturation count is credited when the beat leaves S2; it sticks at all-ones
    assign w_sum = {1'b0, r_sat} + (CNT_W + 1)'(r_s2_pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sat <= '0;
        else if (sat_clr) r_sat <= '0;
        else if (r_s2_vld & out_rdy) r_sat <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
endmodule
